// File: rtl/fourier_seq_ctrl.sv
// Sequencer for an external Fourier core: buffers N samples, streams them into the
// core, waits for completion (with timeout) and exposes the result bins for readback.
module fourier_seq_ctrl #(
  parameter int N   = 10,
  parameter int W   = 64,
  parameter int AW  = $clog2(N),
  parameter int TMO = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  input  logic          start,
  input  logic          clear,
  input  logic [31:0]   regAddr,
  input  logic          regSel,
  output logic [W-1:0]  regData,
  output logic [AW-1:0] core_addr,
  output logic [W-1:0]  core_x,
  output logic [1:0]    core_op,
  input  logic          core_done,
  input  logic [W-1:0]  core_y_re,
  input  logic [W-1:0]  core_y_im,
  output logic          done,
  output logic          err
);

  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [AW:0]    N_CNT    = (AW+1)'(N);
  localparam logic [AW-1:0]  LAST     = AW'(N - 1);
  localparam logic [31:0]    N_ADDR   = 32'(N);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TMO - 1);

  // State encoding doubles as the core operation code.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LOAD    = 2'b01,
    COMPUTE = 2'b10,
    READ    = 2'b11
  } state_t;

  state_t         state, state_n;
  logic [AW:0]    count;
  logic [TW-1:0]  tmo_cnt;
  logic [31:0]    addr_p1;
  logic [AW-1:0]  addr_inc;
  logic [W-1:0]   sample_mem [N];

  assign in_ready = (state == IDLE) && (count != N_CNT);
  assign done     = (state == READ);
  assign addr_inc = core_addr + 1'b1;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start && count == N_CNT) state_n = LOAD;
      LOAD:    if (core_addr == LAST) state_n = COMPUTE;
      COMPUTE: begin
        if (core_done)                 state_n = READ;
        else if (tmo_cnt == TMO_LAST)  state_n = IDLE;
      end
      READ:    if (clear) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Sample buffer carries no reset; it is always fully rewritten before LOAD.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) sample_mem[count[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      tmo_cnt   <= '0;
      err       <= 1'b0;
      core_op   <= 2'b00;
      core_addr <= '0;
      core_x    <= '0;
      addr_p1   <= '0;
    end else begin
      core_op <= state_n;
      addr_p1 <= regAddr;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) count <= count + 1'b1;
          if (state_n == LOAD) begin
            err       <= 1'b0;
            core_addr <= '0;
            core_x    <= sample_mem[0];
          end
        end
        LOAD: begin
          if (state_n == COMPUTE) begin
            core_x  <= '0;
            tmo_cnt <= '0;
          end else begin
            core_addr <= addr_inc;
            core_x    <= sample_mem[addr_inc];
          end
        end
        COMPUTE: begin
          if (core_done) begin
            if (regAddr < N_ADDR) core_addr <= regAddr[AW-1:0];
          end else if (tmo_cnt == TMO_LAST) begin
            err     <= 1'b1;
            count   <= '0;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        READ: begin
          // Out-of-range bins keep the last legal address on the core.
          if (regAddr < N_ADDR) core_addr <= regAddr[AW-1:0];
          if (clear) count <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    regData = '0;
    if (state == READ && addr_p1 < N_ADDR) regData = regSel ? core_y_im : core_y_re;
  end

endmodule

// File: tb/tb_fourier_seq_ctrl.sv
// Scenario bench for fourier_seq_ctrl with a behavioural core model and a sample queue
// as the reference for what LOAD must stream out.
module tb_fourier_seq_ctrl;
  localparam int N   = 10;
  localparam int W   = 64;
  localparam int AW  = $clog2(N);
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset, in_valid, start, clear, regSel, core_done;
  logic [W-1:0]  in_data, regData, core_x, core_y_re, core_y_im;
  logic          in_ready, done, err;
  logic [31:0]   regAddr;
  logic [AW-1:0] core_addr;
  logic [1:0]    core_op;

  int checks = 0;
  int passed = 0;
  logic [W-1:0] smp[$];

  always #5 clk = ~clk;

  // Core model: bin k returns 100+k (real) and -k (imag).
  assign core_y_re = 64'(100) + 64'(core_addr);
  assign core_y_im = 64'(0) - 64'(core_addr);

  fourier_seq_ctrl #(.N(N), .W(W), .AW(AW), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .start(start), .clear(clear), .regAddr(regAddr),
    .regSel(regSel), .regData(regData), .core_addr(core_addr), .core_x(core_x),
    .core_op(core_op), .core_done(core_done), .core_y_re(core_y_re),
    .core_y_im(core_y_im), .done(done), .err(err)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int cnt, input bit seq);
    for (int i = 0; i < cnt; i++) begin
      logic [W-1:0] v;
      v = seq ? W'(smp.size() + 1) : {$urandom, $urandom};
      in_valid = 1'b1;
      in_data  = v;
      checks++;
      if (in_ready !== 1'b1) $display("FAIL fill_ready[%0d] got %b want 1", i, in_ready);
      else passed++;
      smp.push_back(v);
      cycle();
    end
    in_valid = 1'b0;
  endtask

  task automatic start_and_check_load(input string tag);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (core_op !== 2'b01 || core_addr !== AW'(k) || core_x !== smp[k] || in_ready !== 1'b0 || err !== 1'b0)
        $display("FAIL %s_load[%0d] op=%b addr=%0d x=%0h rdy=%b err=%b want op=01 addr=%0d x=%0h rdy=0 err=0",
                 tag, k, core_op, core_addr, core_x, in_ready, err, k, smp[k]);
      else passed++;
      cycle();
    end
    checks++;
    if (core_op !== 2'b10 || core_x !== '0 || in_ready !== 1'b0)
      $display("FAIL %s_compute_entry op=%b x=%0h rdy=%b want op=10 x=0 rdy=0", tag, core_op, core_x, in_ready);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; start = 1'b0; clear = 1'b0;
    regAddr = '0; regSel = 1'b0; core_done = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    checks++;
    if (core_op !== 2'b00 || core_addr !== '0 || core_x !== '0 || done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1 || regData !== '0)
      $display("FAIL reset_state op=%b addr=%0d x=%0h done=%b err=%b rdy=%b data=%0h want 00/0/0/0/0/1/0",
               core_op, core_addr, core_x, done, err, in_ready, regData);
    else passed++;
  endtask

  task automatic test_fill_load();
    smp.delete();
    fill(N, 1'b1);
    // Extra samples while full must be refused and not disturb the buffer.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      checks++;
      if (in_ready !== 1'b0) $display("FAIL full_ready[%0d] got %b want 0", i, in_ready);
      else passed++;
      cycle();
    end
    in_valid = 1'b0;
    start_and_check_load("seq");
  endtask

  task automatic test_compute_read();
    int d;
    int a;
    logic [AW-1:0] exp_addr;
    logic [W-1:0]  exp_data;
    d = $urandom_range(TMO - 4, 1);
    for (int j = 0; j < d; j++) begin
      cycle();
      checks++;
      if (core_op !== 2'b10 || done !== 1'b0 || err !== 1'b0)
        $display("FAIL compute_wait[%0d] op=%b done=%b err=%b want 10/0/0", j, core_op, done, err);
      else passed++;
    end
    regAddr = 32'd3; regSel = 1'b0; core_done = 1'b1;
    cycle();
    core_done = 1'b0;
    checks++;
    if (done !== 1'b1 || core_op !== 2'b11 || regData !== 64'd103)
      $display("FAIL read_entry done=%b op=%b data=%0d want 1/11/103", done, core_op, regData);
    else passed++;
    exp_addr = AW'(3);
    for (int i = 0; i < 12; i++) begin
      if (i == 0)      begin a = 3;  regSel = 1'b1; end
      else if (i == 1) begin a = 12; regSel = 1'b0; end
      else             begin a = $urandom_range(15, 0); regSel = 1'($urandom); end
      regAddr  = 32'(a);
      start    = 1'($urandom);
      in_valid = 1'($urandom);
      in_data  = {$urandom, $urandom};
      cycle();
      if (a < N) begin
        exp_addr = AW'(a);
        exp_data = regSel ? (64'(0) - 64'(a)) : 64'(100 + a);
      end else begin
        exp_data = '0;
      end
      checks++;
      if (regData !== exp_data || core_addr !== exp_addr || done !== 1'b1 || in_ready !== 1'b0 || core_op !== 2'b11)
        $display("FAIL read[%0d] a=%0d sel=%b data=%0h addr=%0d done=%b rdy=%b op=%b want data=%0h addr=%0d done=1 rdy=0 op=11",
                 i, a, regSel, regData, core_addr, done, in_ready, core_op, exp_data, exp_addr);
      else passed++;
    end
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_clear();
    clear = 1'b1; in_valid = 1'b1; in_data = {$urandom, $urandom};
    cycle();
    clear = 1'b0; in_valid = 1'b0;
    checks++;
    if (done !== 1'b0 || core_op !== 2'b00 || in_ready !== 1'b1)
      $display("FAIL clear_exit done=%b op=%b rdy=%b want 0/00/1", done, core_op, in_ready);
    else passed++;
    smp.delete();
    fill(N, 1'b0);
    start_and_check_load("clear");
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    while (err !== 1'b1 && n < 100) begin
      cycle();
      n++;
    end
    checks++;
    if (n !== TMO || err !== 1'b1 || core_op !== 2'b00 || in_ready !== 1'b1 || done !== 1'b0)
      $display("FAIL timeout cycles=%0d err=%b op=%b rdy=%b done=%b want %0d/1/00/1/0", n, err, core_op, in_ready, done, TMO);
    else passed++;
    core_done = 1'b1;
    cycle();
    core_done = 1'b0;
    checks++;
    if (done !== 1'b0 || core_op !== 2'b00 || err !== 1'b1)
      $display("FAIL stray_done done=%b op=%b err=%b want 0/00/1", done, core_op, err);
    else passed++;
  endtask

  task automatic test_partial_start();
    smp.delete();
    fill(7, 1'b0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (core_op !== 2'b00 || in_ready !== 1'b1 || err !== 1'b1)
        $display("FAIL early_start[%0d] op=%b rdy=%b err=%b want 00/1/1", i, core_op, in_ready, err);
      else passed++;
      cycle();
    end
    fill(3, 1'b0);
    checks++;
    if (in_ready !== 1'b0) $display("FAIL partial_full rdy=%b want 0", in_ready);
    else passed++;
    start_and_check_load("partial");
  endtask

  task automatic test_reset_mid_load();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checks++;
    if (core_op !== 2'b00 || core_addr !== '0 || core_x !== '0 || in_ready !== 1'b1)
      $display("FAIL reset_compute op=%b addr=%0d x=%0h rdy=%b want 00/0/0/1", core_op, core_addr, core_x, in_ready);
    else passed++;
    smp.delete();
    fill(N, 1'b1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 4; k++) cycle();
    checks++;
    if (core_op !== 2'b01 || core_addr !== AW'(4))
      $display("FAIL mid_load_pos op=%b addr=%0d want 01/4", core_op, core_addr);
    else passed++;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checks++;
    if (core_op !== 2'b00 || core_addr !== '0 || done !== 1'b0 || in_ready !== 1'b1 || core_x !== '0 || err !== 1'b0)
      $display("FAIL reset_load op=%b addr=%0d done=%b rdy=%b x=%0h err=%b want 00/0/0/1/0/0",
               core_op, core_addr, done, in_ready, core_x, err);
    else passed++;
    smp.delete();
    fill(N, 1'b1);
    start_and_check_load("refill");
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_load();
    test_compute_read();
    test_clear();
    test_timeout();
    test_partial_start();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
